dac_multichannel_interface: RTL and testbench

Parametrised multi-channel SPI master for the serial DAC, successor to the single-channel DAC interface. It watches `CHANNELS` packed sample inputs and detects per-channel changes. Pending channels are served round-robin: each gets one 32-bit write-and-update frame at a programmable SCK rate. It sits between the synth voice/mixer outputs and the board DAC pins. It runs on one clock with no derived clock domains.

---
 rtl/dac_pkg.sv | 26 ++
 rtl/dac_rr_arbiter.sv | 29 ++
 rtl/dac_multichannel_interface.sv | 203 ++++++++++++++++++++
 tb/tb_dac_multichannel_interface.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel serial DAC master:
// frame geometry, default command nibble, FSM state type and frame packing.
package dac_pkg;

  localparam int         DAC_FRAME_W          = 32;
  localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
  localparam int         DAC_ADDR_W           = 4;
  localparam int         DAC_BITCNT_W         = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } dac_state_t;

  // Frame layout: 8 don't-care bits (sent as 0), command, address, left-justified data.
  function automatic logic [DAC_FRAME_W-1:0] dac_build_frame(
    input logic [3:0]            cmd,
    input logic [DAC_ADDR_W-1:0] addr,
    input logic [15:0]           data_left
  );
    return {8'h00, cmd, addr, data_left};
  endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Combinational round-robin picker: returns the first pending channel at or
// after rr_ptr, searching cyclically, plus a flag telling whether any was pending.
module dac_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] pending,
  input  logic [PTR_W-1:0]    rr_ptr,
  output logic [PTR_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending channel wins last.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      idx = PTR_W'((int'(rr_ptr) + off) % CHANNELS);
      if (pending[idx]) begin
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_multichannel_interface.sv
// Multi-channel SPI master for the serial DAC. Channels whose sample changed
// (or that are forced) are sent round-robin as 32-bit write-and-update frames.
// Optional MISO echo capture/compare is built when DAC_READBACK_EN is defined.
module dac_multichannel_interface
  import dac_pkg::*;
#(
  parameter int         CHANNELS    = 4,
  parameter int         DATA_W      = 12,
  parameter int         CLK_DIV     = 2,
  parameter logic [3:0] DAC_COMMAND = DAC_CMD_WRITE_UPDATE
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic [CHANNELS*DATA_W-1:0] DATA_IN,
  input  logic                       UPDATE_ALL,
  input  logic                       SPI_MISO,
  output logic                       SPI_MOSI,
  output logic                       SPI_SCK,
  output logic                       DAC_CS,
  output logic                       DAC_CLR,
  output logic                       BUSY,
  output logic [31:0]                RDBK_DATA,
  output logic                       RDBK_VALID,
  output logic                       RDBK_MISMATCH
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DAC_BITCNT_W-1:0] BIT_LAST = DAC_BITCNT_W'(DAC_FRAME_W - 1);

  dac_state_t             state_reg;
  logic [DIV_W-1:0]       div_cnt_reg;
  logic [DAC_BITCNT_W-1:0] bit_cnt_reg;
  logic [DAC_FRAME_W-1:0] shift_reg;
  logic                   cs_reg, sck_reg, mosi_reg, busy_reg, clr_reg;
  logic [PTR_W-1:0]       rr_reg, rr_next;
  logic [CHANNELS-1:0]    force_reg, force_next;
  logic [DATA_W-1:0]      last_sent_reg [CHANNELS];

  logic [DATA_W-1:0]      data_slice [CHANNELS];
  logic [CHANNELS-1:0]    pending;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic [DAC_FRAME_W-1:0] frame_word;
  logic                   div_done, load_now, cs_rise;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign data_slice[gi] = DATA_IN[gi*DATA_W +: DATA_W];
    assign pending[gi]    = (data_slice[gi] != last_sent_reg[gi]) || force_reg[gi];
  end

  dac_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .PTR_W    (PTR_W)
  ) u_arb (
    .pending     (pending),
    .rr_ptr      (rr_reg),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign frame_word = dac_build_frame(DAC_COMMAND, DAC_ADDR_W'(grant_idx),
                                      16'(data_slice[grant_idx]) << (16 - DATA_W));
  assign div_done   = (div_cnt_reg == DIV_LAST);
  assign load_now   = (state_reg == IDLE) && grant_valid;
  assign cs_rise    = (state_reg == SHIFT) && !sck_reg && div_done && (bit_cnt_reg == BIT_LAST);
  assign rr_next    = (grant_idx == PTR_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

  // Force bits clear on load, but a simultaneous UPDATE_ALL re-marks everything.
  always_comb begin
    force_next = force_reg;
    if (load_now) force_next[grant_idx] = 1'b0;
    if (UPDATE_ALL) force_next = '1;
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT (32 SCK periods) -> GAP, with registered pins.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      cs_reg      <= 1'b1;
      sck_reg     <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      clr_reg     <= 1'b0;
      rr_reg      <= '0;
      force_reg   <= '1;
      for (int k = 0; k < CHANNELS; k++) last_sent_reg[k] <= '0;
    end else begin
      clr_reg   <= 1'b1;
      force_reg <= force_next;
      case (state_reg)
        IDLE: begin
          div_cnt_reg <= '0;
          if (grant_valid) begin
            state_reg                <= SETUP;
            shift_reg                <= frame_word;
            mosi_reg                 <= frame_word[DAC_FRAME_W-1];
            cs_reg                   <= 1'b0;
            busy_reg                 <= 1'b1;
            bit_cnt_reg              <= '0;
            rr_reg                   <= rr_next;
            last_sent_reg[grant_idx] <= data_slice[grant_idx];
          end
        end
        SETUP: begin
          if (div_done) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b1;
            state_reg   <= SHIFT;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (!div_done) begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end else begin
            div_cnt_reg <= '0;
            if (sck_reg) begin
              // Falling edge: present the next bit; zeros follow bit 0.
              sck_reg   <= 1'b0;
              shift_reg <= {shift_reg[DAC_FRAME_W-2:0], 1'b0};
              mosi_reg  <= shift_reg[DAC_FRAME_W-2];
            end else if (bit_cnt_reg == BIT_LAST) begin
              state_reg <= GAP;
              cs_reg    <= 1'b1;
              mosi_reg  <= 1'b0;
            end else begin
              sck_reg     <= 1'b1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        GAP: begin
          if (div_done) begin
            div_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign SPI_MOSI = mosi_reg;
  assign SPI_SCK  = sck_reg;
  assign DAC_CS   = cs_reg;
  assign DAC_CLR  = clr_reg;
  assign BUSY     = busy_reg;

`ifdef DAC_READBACK_EN
  logic                   sck_rise;
  logic [DAC_FRAME_W-1:0] rx_reg, cur_frame_reg, prev_frame_reg, rdbk_data_reg;
  logic                   has_prev_reg, rdbk_valid_reg, rdbk_mm_reg;

  assign sck_rise = ((state_reg == SETUP) && div_done) ||
                    ((state_reg == SHIFT) && !sck_reg && div_done && (bit_cnt_reg != BIT_LAST));

  // Capture MISO on SCK rise; at frame end compare against the frame sent before this one.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      rx_reg         <= '0;
      cur_frame_reg  <= '0;
      prev_frame_reg <= '0;
      rdbk_data_reg  <= '0;
      has_prev_reg   <= 1'b0;
      rdbk_valid_reg <= 1'b0;
      rdbk_mm_reg    <= 1'b0;
    end else begin
      rdbk_valid_reg <= cs_rise;
      rdbk_mm_reg    <= 1'b0;
      if (load_now) begin
        cur_frame_reg  <= frame_word;
        prev_frame_reg <= cur_frame_reg;
      end
      if (sck_rise) rx_reg <= {rx_reg[DAC_FRAME_W-2:0], SPI_MISO};
      if (cs_rise) begin
        rdbk_data_reg <= rx_reg;
        rdbk_mm_reg   <= has_prev_reg && (rx_reg != prev_frame_reg);
        has_prev_reg  <= 1'b1;
      end
    end
  end

  assign RDBK_DATA     = rdbk_data_reg;
  assign RDBK_VALID    = rdbk_valid_reg;
  assign RDBK_MISMATCH = rdbk_mm_reg;
`else
  logic unused_miso;
  assign unused_miso   = SPI_MISO ^ cs_rise;
  assign RDBK_DATA     = '0;
  assign RDBK_VALID    = 1'b0;
  assign RDBK_MISMATCH = 1'b0;
`endif

endmodule

// File: tb/tb_dac_multichannel_interface.sv
// Scoreboard bench for dac_multichannel_interface (CHANNELS=4, DATA_W=12, CLK_DIV=2).
module tb_dac_multichannel_interface;

  localparam int CH  = 4;
  localparam int DW  = 12;
  localparam int DIV = 2;
  localparam int CS_LOW = 65 * DIV;
  localparam int PERIOD = 66 * DIV + 1;

  typedef struct {
    logic [31:0] word;
    int          period;
  } exp_t;

  logic            CLK_IN = 1'b0;
  logic            RST_IN = 1'b1;
  logic [CH*DW-1:0] DATA_IN = '0;
  logic            UPDATE_ALL = 1'b0;
  logic            SPI_MISO = 1'b0;
  logic            SPI_MOSI, SPI_SCK, DAC_CS, DAC_CLR, BUSY;
  logic [31:0]     RDBK_DATA;
  logic            RDBK_VALID, RDBK_MISMATCH;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] miso_word = '0;
  bit          flip_req = 1'b0;

  dac_multichannel_interface #(
    .CHANNELS    (CH),
    .DATA_W      (DW),
    .CLK_DIV     (DIV),
    .DAC_COMMAND (4'b0011)
  ) dut (
    .CLK_IN        (CLK_IN),
    .RST_IN        (RST_IN),
    .DATA_IN       (DATA_IN),
    .UPDATE_ALL    (UPDATE_ALL),
    .SPI_MISO      (SPI_MISO),
    .SPI_MOSI      (SPI_MOSI),
    .SPI_SCK       (SPI_SCK),
    .DAC_CS        (DAC_CS),
    .DAC_CLR       (DAC_CLR),
    .BUSY          (BUSY),
    .RDBK_DATA     (RDBK_DATA),
    .RDBK_VALID    (RDBK_VALID),
    .RDBK_MISMATCH (RDBK_MISMATCH)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge CLK_IN);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input int period);
    exp_t e;
    e.word   = w;
    e.period = period;
    exp_q.push_back(e);
    $display("expect frame %08h period %0d", w, period);
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    DATA_IN[k*DW +: DW] = v;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 32'((exp_q.size() == 0) && !BUSY), 32'd1);
    repeat (20) step();
    check("idle_cs_high", 32'(DAC_CS), 32'd1);
  endtask

  // Monitor: rebuilds each frame from MOSI on SCK rises, pops and compares at CS rise.
  // Also drives MISO as an echo of the last completed frame.
  initial begin
    bit          cs_p, sck_p, active, flip_lat, tb_has_prev;
    int          low_cnt, nbits, since_fall, period_seen, idx;
    logic [31:0] rx, drive_word;
    exp_t        e;
    cs_p = 1'b1; sck_p = 1'b0; active = 1'b0; flip_lat = 1'b0; tb_has_prev = 1'b0;
    low_cnt = 0; nbits = 0; since_fall = 0; period_seen = 0; idx = 31;
    rx = '0; drive_word = '0;
    forever begin
      @(negedge CLK_IN);
      since_fall++;
      if (RST_IN) begin
        active      = 1'b0;
        tb_has_prev = 1'b0;
      end else begin
        if (!DAC_CS && cs_p) begin
          active      = 1'b1;
          low_cnt     = 0;
          nbits       = 0;
          rx          = '0;
          period_seen = since_fall;
          since_fall  = 0;
          drive_word  = miso_word;
          flip_lat    = flip_req;
          idx         = 31;
        end
        if (active && !DAC_CS) begin
          low_cnt++;
          if (SPI_SCK && !sck_p) begin
            rx = {rx[30:0], SPI_MOSI};
            nbits++;
          end
          if (!SPI_SCK && sck_p && idx > 0) idx--;
        end
        if (active && DAC_CS && !cs_p) begin
          active = 1'b0;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: got %08h expected none", rx);
          end else begin
            e = exp_q.pop_front();
            $display("frame %08h cs_low %0d period %0d", rx, low_cnt, period_seen);
            check("frame_word", rx, e.word);
            check("cs_low_cycles", 32'(low_cnt), 32'(CS_LOW));
            check("bit_count", 32'(nbits), 32'd32);
            if (e.period != 0) check("frame_period", 32'(period_seen), 32'(e.period));
`ifdef DAC_READBACK_EN
            check("rdbk_valid", 32'(RDBK_VALID), 32'd1);
            check("rdbk_data", RDBK_DATA, drive_word ^ (flip_lat ? 32'h20 : 32'h0));
            check("rdbk_mismatch", 32'(RDBK_MISMATCH), 32'(tb_has_prev && flip_lat));
`else
            check("rdbk_valid_off", 32'(RDBK_VALID), 32'd0);
`endif
            miso_word   = e.word;
            tb_has_prev = 1'b1;
          end
        end
      end
      SPI_MISO = drive_word[idx] ^ (flip_lat && idx == 5);
      cs_p  = DAC_CS;
      sck_p = SPI_SCK;
    end
  end

  initial begin
    int n, rises;
    bit prev;

    // Reset state
    repeat (3) step();
    check("rst_cs", 32'(DAC_CS), 32'd1);
    check("rst_sck", 32'(SPI_SCK), 32'd0);
    check("rst_mosi", 32'(SPI_MOSI), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_clr", 32'(DAC_CLR), 32'd0);
    check("rst_rdbk", {RDBK_DATA[29:0], RDBK_VALID, RDBK_MISMATCH}, 32'd0);

    // Release: every channel forced, sent 0..3 in order
    push(32'h0030_0000, 0);
    push(32'h0031_0000, PERIOD);
    push(32'h0032_0000, PERIOD);
    push(32'h0033_0000, PERIOD);
    RST_IN = 1'b0;
    step();
    check("clr_after_release", 32'(DAC_CLR), 32'd1);
    check("cs_on_load_edge", 32'(DAC_CS), 32'd0);
    check("busy_on_load", 32'(BUSY), 32'd1);
    wait_drain(2000);

    // Single channel change
    push(32'h0032_ABC0, 0);
    set_ch(2, 12'hABC);
    wait_drain(1000);

    // Move rr to 2 by sending channel 1, then change 1 and 3 together
    push(32'h0031_1110, 0);
    set_ch(1, 12'h111);
    wait_drain(1000);
    push(32'h0033_3330, 0);
    push(32'h0031_2220, PERIOD);
    set_ch(1, 12'h222);
    set_ch(3, 12'h333);
    wait_drain(1000);

    // UPDATE_ALL on the load cycle of channel 0
    push(32'h0030_0550, 0);
    push(32'h0031_2220, PERIOD);
    push(32'h0032_ABC0, PERIOD);
    push(32'h0033_3330, PERIOD);
    push(32'h0030_0550, PERIOD);
    set_ch(0, 12'h055);
    UPDATE_ALL = 1'b1;
    step();
    UPDATE_ALL = 1'b0;
    wait_drain(2000);

    // Reset during bit 10 of a channel 2 frame
    set_ch(2, 12'h123);
    n = 0; rises = 0; prev = 1'b0;
    while (rises < 11 && n < 1000) begin
      step();
      if (SPI_SCK && !prev) rises++;
      prev = SPI_SCK;
      n++;
    end
    check("reached_bit10", 32'(rises), 32'd11);
    check("sck_high_before_rst", 32'(SPI_SCK), 32'd1);
    RST_IN = 1'b1;
    #1;
    check("async_rst_cs", 32'(DAC_CS), 32'd1);
    check("async_rst_sck", 32'(SPI_SCK), 32'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    push(32'h0030_0550, 0);
    push(32'h0031_2220, PERIOD);
    push(32'h0032_1230, PERIOD);
    push(32'h0033_3330, PERIOD);
    repeat (3) step();
    RST_IN = 1'b0;
    wait_drain(2000);

    // Corrupted echo on the next frame
    flip_req = 1'b1;
    push(32'h0031_4440, 0);
    set_ch(1, 12'h444);
    wait_drain(1000);
    flip_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
